// File: rtl/alu_muldiv.sv
// alu_muldiv: multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO.
// Optional ALU_MULDIV_FAST_MUL_EN: single-cycle multiply in FIX.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Start_in,
    input  logic [5:0]       Func_in,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             Busy_out,
    output logic             Done_out,
    output logic [WIDTH-1:0] Hi_out,
    output logic [WIDTH-1:0] Lo_out
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   araw_q, araw_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_q, div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               divz_q, divz_d;

    logic               is_mul, is_div, is_mthi, is_mtlo, is_sgn;
    logic               accept, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     rem_sh, diff;
    logic [2*WIDTH-1:0] mul_step, div_step, prod, prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    // Decode the function field into operation classes.
    always_comb begin
        is_mul  = 1'b0;
        is_div  = 1'b0;
        is_mthi = 1'b0;
        is_mtlo = 1'b0;
        is_sgn  = 1'b0;
        unique case (Func_in)
            F_MULT:  begin is_mul = 1'b1; is_sgn = 1'b1; end
            F_MULTU: is_mul = 1'b1;
            F_DIV:   begin is_div = 1'b1; is_sgn = 1'b1; end
            F_DIVU:  is_div = 1'b1;
            F_MTHI:  is_mthi = 1'b1;
            F_MTLO:  is_mtlo = 1'b1;
            default: ;
        endcase
    end

    assign accept = Start_in && (state_q == S_IDLE || state_q == S_DONE);
    assign a_neg  = is_sgn && A_in[WIDTH-1];
    assign b_neg  = is_sgn && B_in[WIDTH-1];
    assign a_mag  = a_neg ? -A_in : A_in;
    assign b_mag  = b_neg ? -B_in : B_in;

    // MSB-first shift-add: acc = 2*acc + (multiplier bit ? multiplicand : 0).
    assign mul_step = {acc_q[2*WIDTH-2:0], 1'b0}
                    + (b_q[WIDTH-1] ? {{WIDTH{1'b0}}, a_q} : '0);

    // Restoring divide: upper half is remainder, lower half collects quotient.
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    assign diff     = rem_sh - {1'b0, b_q};
    assign div_step = diff[WIDTH]
                    ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                    : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

`ifdef ALU_MULDIV_FAST_MUL_EN
    assign prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`else
    assign prod = acc_q;
`endif

    assign prod_fix = neg_q ? -prod : prod;
    assign q_fix    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign r_fix    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH]
                             : acc_q[2*WIDTH-1:WIDTH];

    // Next-state logic for the control FSM and datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        araw_d  = araw_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        divz_d  = divz_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept && is_mthi) begin
                    hi_d    = A_in;
                    state_d = S_DONE;
                end else if (accept && is_mtlo) begin
                    lo_d    = A_in;
                    state_d = S_DONE;
                end else if (accept && (is_mul || is_div)) begin
                    a_d     = a_mag;
                    b_d     = b_mag;
                    araw_d  = A_in;
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    div_d   = is_div;
                    divz_d  = is_div && (B_in == '0);
                    acc_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = S_RUN;
`ifdef ALU_MULDIV_FAST_MUL_EN
                    if (is_mul) state_d = S_FIX;
`endif
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (div_q) begin
                    acc_d = div_step;
                    a_d   = {a_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = mul_step;
                    b_d   = {b_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (div_q && divz_q) begin
                    lo_d = '1;
                    hi_d = araw_q;
                end else if (div_q) begin
                    lo_d = q_fix;
                    hi_d = r_fix;
                end else begin
                    lo_d = prod_fix[WIDTH-1:0];
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            araw_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            araw_q  <= araw_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            divz_q  <= divz_d;
        end
    end

    assign Busy_out = (state_q == S_RUN) || (state_q == S_FIX);
    assign Done_out = (state_q == S_DONE);
    assign Hi_out   = hi_q;
    assign Lo_out   = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vectors for alu_muldiv at WIDTH 32 and 8.
// Latency expectations follow ALU_MULDIV_FAST_MUL_EN when defined.
module tb_alu_muldiv;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

`ifdef ALU_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT  = 2;
    localparam int MUL_BUSY = 1;
    localparam int MUL8_LAT = 2;
    localparam int PULSE_C  = 1;
`else
    localparam int MUL_LAT  = 34;
    localparam int MUL_BUSY = 33;
    localparam int MUL8_LAT = 10;
    localparam int PULSE_C  = 5;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  func;
    logic [31:0] a, b, hi, lo;
    logic        busy, done;

    logic        s8;
    logic [5:0]  f8;
    logic [7:0]  a8, b8, hi8, lo8;
    logic        busy8, done8;

    int n_tests = 0;
    int n_fail  = 0;
    int lat, nb, ndone;

    alu_muldiv #(.WIDTH(32)) dut (
        .clock(clk), .reset(rst), .Start_in(start), .Func_in(func),
        .A_in(a), .B_in(b), .Busy_out(busy), .Done_out(done),
        .Hi_out(hi), .Lo_out(lo)
    );

    alu_muldiv #(.WIDTH(8)) dut8 (
        .clock(clk), .reset(rst), .Start_in(s8), .Func_in(f8),
        .A_in(a8), .B_in(b8), .Busy_out(busy8), .Done_out(done8),
        .Hi_out(hi8), .Lo_out(lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, scramble operands, then wait for Done.
    task automatic op(input logic [5:0] f, input logic [31:0] av,
                      input logic [31:0] bv, output int l, output int n);
        start = 1'b1;
        func  = f;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        l     = 0;
        n     = 0;
        for (int c = 1; c < 60; c++) begin
            if (busy) n++;
            if (done) begin
                l = c;
                break;
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; func = '0; a = '0; b = '0;
        s8 = 1'b0; f8 = '0; a8 = '0; b8 = '0;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst = 1'b0;
        tick();

        op(F_MTHI, 32'hCAFEF00D, 32'h0, lat, nb);
        check("mthi_lat", 64'(lat), 64'd1);
        check("mthi_busy", 64'(nb), 64'd0);
        check("mthi_hi", 64'(hi), 64'hCAFEF00D);
        check("mthi_lo", 64'(lo), 64'd0);

        op(F_MTLO, 32'h12345678, 32'h0, lat, nb);
        check("mtlo_lat", 64'(lat), 64'd1);
        check("mtlo_busy", 64'(nb), 64'd0);
        check("mtlo_lo", 64'(lo), 64'h12345678);
        check("mtlo_hi", 64'(hi), 64'hCAFEF00D);
        tick();

        op(6'b100000, 32'h5, 32'h6, lat, nb);
        check("ill_done", 64'(lat), 64'd0);
        check("ill_busy", 64'(nb), 64'd0);
        check("ill_hilo", {hi, lo}, 64'hCAFEF00D_12345678);

        op(F_MULT, 32'hFFFFFFFD, 32'h5, lat, nb);
        check("mult_lat", 64'(lat), 64'(MUL_LAT));
        check("mult_busy", 64'(nb), 64'(MUL_BUSY));
        check("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        tick();

        op(F_DIVU, 32'd100, 32'd7, lat, nb);
        check("divu_lat", 64'(lat), 64'd34);
        check("divu_busy", 64'(nb), 64'd33);
        check("divu_hilo", {hi, lo}, 64'h00000002_0000000E);

        op(F_DIV, 32'hFFFFFFF9, 32'd2, lat, nb);
        check("div_b2b_lat", 64'(lat), 64'd34);
        check("div_b2b_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

        op(F_DIV, 32'h80000000, 32'hFFFFFFFF, lat, nb);
        check("div_ovf_lat", 64'(lat), 64'd34);
        check("div_ovf_hilo", {hi, lo}, 64'h00000000_80000000);

        op(F_DIVU, 32'h1234, 32'h0, lat, nb);
        check("divz_lat", 64'(lat), 64'd34);
        check("divz_hilo", {hi, lo}, 64'h00001234_FFFFFFFF);
        tick();
        check("done_1cyc", 64'(done), 64'd0);

        start = 1'b1; func = F_MULTU;
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        tick();
        start = 1'b0;
        lat = 0; ndone = 0;
        for (int c = 1; c < 45; c++) begin
            if (c == PULSE_C) begin
                start = 1'b1; func = F_DIVU; a = 32'd9; b = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (lat == 0) lat = c;
            end
            tick();
        end
        start = 1'b0;
        check("multu_lat", 64'(lat), 64'(MUL_LAT));
        check("multu_ndone", 64'(ndone), 64'd1);
        check("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);

        start = 1'b1; func = F_DIV; a = 32'hFFFFFF9C; b = 32'd3;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_hilo", {hi, lo}, 64'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) ndone++;
            tick();
        end
        check("mid_rst_quiet", 64'(ndone), 64'd0);
        check("post_rst_hilo", {hi, lo}, 64'd0);

        s8 = 1'b1; f8 = F_MULT; a8 = 8'h7F; b8 = 8'h80;
        tick();
        s8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        lat = 0;
        for (int c = 1; c < 30; c++) begin
            if (done8) begin
                lat = c;
                break;
            end
            tick();
        end
        check("w8_lat", 64'(lat), 64'(MUL8_LAT));
        check("w8_hilo", 64'({hi8, lo8}), 64'h0000C080);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Multi-cycle multiply/divide unit with architectural HI/LO registers, parametrised in datapath width; companion to the single-cycle ALU in the execute stage. It accepts MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO operations through a start/busy/done handshake. Multiply uses iterative shift-add and divide uses iterative restoring division, one bit per cycle. The pipeline stalls on Busy_out and reads Hi_out/Lo_out for MFHI/MFLO.

## Interface
- WIDTH, 32: operand and HI/LO width; legal range ≥ 4.
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- Start_in  input  1  request; sampled only when accepting (IDLE or DONE).
- Func_in  input  6  MIPS funct:
  - 011000 MULT
  - 011001 MULTU
  - 011010 DIV
  - 011011 DIVU
  - 010001 MTHI
  - 010011 MTLO
  - any other value: request ignored.
- A_in  input  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- B_in  input  WIDTH  multiplier / divisor.
- Busy_out  output  1  operation in flight; new requests ignored.
- Done_out  output  1  one-cycle pulse; HI/LO hold the new result.
- Hi_out  output  WIDTH  HI register: product upper half, or remainder.
- Lo_out  output  WIDTH  LO register: product lower half, or quotient.

## Operation
- States: IDLE, RUN, FIX, DONE.
- Accepting a request in IDLE or DONE with a legal mul/div funct:
  - latch operand magnitudes (absolute values for signed ops; raw values for unsigned);
  - latch the result-sign flags;
  - clear the accumulator;
  - load counter = WIDTH;
  - go to RUN.
- RUN: one iteration per cycle; counter decrements; at counter = 1 go to FIX.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract yields quotient and remainder magnitudes.
- FIX: apply the sign fixup, write HI/LO, go to DONE.
  - MULT: negate the 2·WIDTH product if the operand signs differ.
  - DIV: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
- DONE: Done_out = 1 for one cycle. Next state is IDLE, or RUN/FIX if a new request is accepted in the same cycle.
- MTHI/MTLO accepted: write Hi_out/Lo_out = A_in at that edge, go to DONE; the other register is unchanged.
- Divide by zero (DIV or DIVU, B_in = 0): Lo = all ones, Hi = A_in unmodified; no sign fixup.
- Signed overflow (DIV, A = 1 followed by WIDTH-1 zeros, B = all ones): Lo = 1 followed by WIDTH-1 zeros, Hi = 0.
- HI/LO are written only in FIX or by MTHI/MTLO; they hold their value otherwise.
- Illegal funct with Start_in: no state change, no Done_out.

## Timing
- Request sampled at the end of cycle 0.
- Iterative mul/div:
  - RUN occupies cycles 1..WIDTH; FIX is cycle WIDTH+1.
  - Done_out and new HI/LO are visible in cycle WIDTH+2 (cycle 34 for WIDTH = 32).
- MTHI/MTLO: new value and Done_out in cycle 1; Busy_out never asserts.
- Busy_out = (state == RUN or FIX); decoded directly from state.
- Back-to-back: a request in the DONE cycle is accepted with no bubble.
- Start_in while Busy_out = 1: ignored, not queued.
- Operands are captured at acceptance; later changes to A_in/B_in have no effect.
- Reset (any state, including mid-operation), effective at the next edge:
  - state = IDLE; Busy_out = 0; Done_out = 0; Hi_out = 0; Lo_out = 0;
  - the in-flight result is discarded.
- Counter width: clog2(WIDTH+1) bits.

## Configuration
- ALU_MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU go IDLE → FIX → DONE;
  - FIX computes the full product with a single-cycle multiplier from the latched operands;
  - Busy_out is high in cycle 1 only; Done_out and HI/LO appear in cycle 2.
  - Divide timing is unchanged.
- Undefined: all multiplies use the iterative WIDTH+2-cycle path; no hardware multiplier is inferred.

## Test plan
- WIDTH = 32, MULT A = FFFFFFFD (-3), B = 00000005 → cycle 34: Done_out = 1, Hi = FFFFFFFF, Lo = FFFFFFF1. Busy_out high in cycles 1–33. With FAST_MUL_EN the same result arrives in cycle 2.
- DIVU 100 / 7 → Lo = 0000000E, Hi = 00000002. Then DIV -7 / 2 issued in the DONE cycle → accepted, Lo = FFFFFFFD, Hi = FFFFFFFF.
- DIV 80000000 / FFFFFFFF → Lo = 80000000, Hi = 0. DIVU 1234 / 0 → Lo = FFFFFFFF, Hi = 00001234.
- MULTU FFFFFFFF × FFFFFFFF, with Start_in + DIVU pulsed in cycle 5 → request ignored; Hi = FFFFFFFE, Lo = 00000001; exactly one Done_out pulse.
- MTHI A = CAFEF00D → cycle 1: Hi = CAFEF00D, Lo unchanged, Done_out = 1, Busy_out stays 0. MTLO behaves symmetrically.
- Reset asserted in cycle 10 of a DIV → next cycle: IDLE, Busy_out = 0, Hi = Lo = 0, and no Done_out follows. Repeat at WIDTH = 8 with MULT 7F × 80 → Hi = C0, Lo = 80.
